// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/execute/memory hazard-control bundle between the pipeline datapath (master)
// and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              valid_D;
  logic [REG_AW-1:0] rs1_D;
  logic [REG_AW-1:0] rs2_D;
  logic              rs1_used_D;
  logic              rs2_used_D;
  logic [REG_AW-1:0] rd_D;
  logic              reg_wr_D;
  logic              rd_en_D;
  logic              wr_en_D;
  logic              br_taken_E;
  logic              mem_ack;

  logic              stall_F;
  logic              stall_D;
  logic              flush_D;
  logic              flush_E;
  logic              freeze;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_req;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output valid_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D,
           reg_wr_D, rd_en_D, wr_en_D, br_taken_E, mem_ack,
    input  stall_F, stall_D, flush_D, flush_E, freeze, fwd_a, fwd_b,
           mem_req, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_D, rs1_D, rs2_D, rs1_used_D, rs2_used_D, rd_D,
           reg_wr_D, rd_en_D, wr_en_D, br_taken_E, mem_ack,
    output stall_F, stall_D, flush_D, flush_E, freeze, fwd_a, fwd_b,
           mem_req, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use stall, branch flush and
// wait-state memory freeze with timeout. Define HAZARD_PERF_EN for stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = 8;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_wr;
    logic              is_load;
    logic              is_mem;
  } rec_t;

  typedef struct packed {
    rec_t              r;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } erec_t;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ABORT} state_t;

  erec_t             e_q, e_d, d_rec;
  rec_t              m_q, m_d, w_q, w_d;
  state_t            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              err_q;

  logic mem_req, freeze, load_use, branch, lu_stall, stall;

  function automatic logic [1:0] fwd_sel(input rec_t m, input rec_t w,
                                         input logic [REG_AW-1:0] rs);
    if (m.valid && m.reg_wr && !m.is_load && m.rd != '0 && m.rd == rs) return 2'd1;
    if (w.valid && w.reg_wr && w.rd != '0 && w.rd == rs)                return 2'd2;
    return 2'd0;
  endfunction

  assign mem_req  = m_q.valid & m_q.is_mem & (state_q != S_ABORT);
  assign freeze   = mem_req & ~bus.mem_ack;
  assign load_use = e_q.r.valid & e_q.r.is_load & (e_q.r.rd != '0) & bus.valid_D &
                    ((bus.rs1_used_D & (bus.rs1_D == e_q.r.rd)) |
                     (bus.rs2_used_D & (bus.rs2_D == e_q.r.rd)));
  assign branch   = bus.br_taken_E & ~freeze;
  assign lu_stall = load_use & ~freeze & ~bus.br_taken_E;
  assign stall    = freeze | lu_stall;

  // Controls are forced low while rst is high because some depend on live inputs.
  assign bus.mem_req = ~rst & mem_req;
  assign bus.freeze  = ~rst & freeze;
  assign bus.stall_F = ~rst & stall;
  assign bus.stall_D = ~rst & stall;
  assign bus.flush_D = ~rst & branch;
  assign bus.flush_E = ~rst & (branch | lu_stall);
  assign bus.fwd_a   = fwd_sel(m_q, w_q, e_q.rs1);
  assign bus.fwd_b   = fwd_sel(m_q, w_q, e_q.rs2);
  assign bus.mem_err = err_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    d_rec.r.valid   = bus.valid_D;
    d_rec.r.rd      = bus.rd_D;
    d_rec.r.reg_wr  = bus.reg_wr_D;
    d_rec.r.is_load = bus.rd_en_D;
    d_rec.r.is_mem  = bus.rd_en_D | bus.wr_en_D;
    d_rec.rs1       = bus.rs1_D;
    d_rec.rs2       = bus.rs2_D;

    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (freeze) begin
      w_d = '0;
    end else begin
      // An aborted access leaves M as a bubble so its register write never lands.
      w_d = (state_q == S_ABORT) ? '0 : m_q;
      m_d = e_q.r;
      e_d = (branch | lu_stall) ? '0 : d_rec;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          cnt_q <= '0;
          if (freeze) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mem_ack) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end else if (cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
            state_q <= S_ABORT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_ABORT: begin
          err_q   <= 1'b1;
          state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the pipelined RISC-V core.
- Tracks in-flight destination registers for the E, M and W stages internally.
- Generates operand-forwarding selects for the execute-stage A/B muxes, load-use stalls, branch flushes, and freeze control for a wait-state data memory (req/ack handshake).
- Sits beside the Decode/Execute pipeline registers and drives their stall/flush controls.

Parameters:
- REG_AW, 5, register address width.
- MAX_WAIT, 15, memory wait cycles before timeout (1..255).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_D  in  1  decode stage holds a real instruction.
- rs1_D  in  REG_AW  decode source 1 address.
- rs2_D  in  REG_AW  decode source 2 address.
- rs1_used_D  in  1  instruction reads rs1.
- rs2_used_D  in  1  instruction reads rs2.
- rd_D  in  REG_AW  decode destination.
- reg_wr_D  in  1  instruction writes rd.
- rd_en_D  in  1  instruction is a load.
- wr_en_D  in  1  instruction is a store.
- br_taken_E  in  1  execute-stage branch/jump taken.
- mem_ack  in  1  data memory completes current access.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold decode register.
- flush_D  out  1  clear decode register next edge.
- flush_E  out  1  load bubble into execute register next edge.
- freeze  out  1  hold E and M pipeline registers.
- fwd_a  out  2  A operand source: 0 reg file, 1 M-stage ALU result, 2 W-stage wdata.
- fwd_b  out  2  B operand source, same encoding.
- mem_req  out  1  data memory access request.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  CNT_W  stall cycles (optional feature).
- flush_cnt  out  CNT_W  branch flushes (optional feature).

Behaviour:
- Stage records E, M and W each hold {valid, rd, reg_wr, is_load, is_mem}; E additionally holds rs1 and rs2.
- Reset: all records invalid, FSM=RUN, wait counter 0, mem_err=0, counters 0.
- Reset takes effect immediately mid-operation; mem_req, stall and flush outputs drop combinationally.
- mem_req = M.valid & M.is_mem & state!=ABORT.
- freeze = mem_req & !mem_ack. Zero-wait ack gives no freeze.
- load_use = E.valid & E.is_load & E.rd!=0 & valid_D & ((rs1_used_D & rs1_D==E.rd) | (rs2_used_D & rs2_D==E.rd)).
- Priority: freeze > br_taken_E > load_use.
- Freeze:
  - stall_F = stall_D = 1.
  - E and M hold; W <= bubble.
- Branch taken:
  - flush_D = flush_E = 1; the branch itself advances.
  - E <= bubble, M <= E, W <= M.
  - A simultaneous load_use is ignored.
- Load-use:
  - stall_F = stall_D = flush_E = 1.
  - E <= bubble, M <= E, W <= M.
- Normal operation: E <= D fields (valid_D gated), M <= E, W <= M.
- Forwarding, combinational on E.rs1 (same for rs2/fwd_b):
  - 1 if M.valid & M.reg_wr & !M.is_load & M.rd!=0 & M.rd==E.rs1.
  - Else 2 if W.valid & W.reg_wr & W.rd!=0 & W.rd==E.rs1.
  - Else 0.
  - M has priority over W; x0 never forwards.
- FSM:
  - RUN -> WAIT when freeze.
  - WAIT: counter increments each cycle. On mem_ack -> RUN, counter cleared. On counter==MAX_WAIT -> ABORT.
  - ABORT (one cycle): mem_req=0, mem_err<=1 (sticky until rst), M moved to W as bubble (write suppressed), -> RUN.
- Outputs are otherwise 0.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with stall_D=1.
  - flush_cnt increments on every branch flush.
  - Both wrap at 2^CNT_W and clear on rst.
- Undefined: both counters tied to 0 and no counter flops are synthesized.

Test Plan:
- add x1,x2,x3 then add x4,x1,x5 -> fwd_a=1 the cycle the second add is in E; no stall.
- lw x5,0(x2) then add x6,x5,x7 -> stall_F=stall_D=flush_E=1 for exactly 1 cycle, then fwd_a=2 with the add in E.
- br_taken_E=1 while load_use is also true -> flush_D=flush_E=1, stall_D=0; flush_cnt +1 with HAZARD_PERF_EN.
- sw in M with mem_ack arriving 3 cycles after mem_req rises -> freeze=1 for 3 cycles, mem_req high 4 cycles, W bubbles; then RUN.
- mem_ack held 0, MAX_WAIT=15 -> ABORT after 15 WAIT cycles, mem_err=1 and stays 1; a later access completes normally.
- rst asserted mid-WAIT -> mem_req, freeze and fwd_* are 0 immediately; all records invalid; mem_err=0.
